// File: rtl/mau_pkg.sv
// Shared state encoding, funct3 constants and request classification helpers
// for the mem_access_unit load/store requester.
package mau_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RMW   = 2'd2,
    ST_STORE = 2'd3
  } mau_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Stores only know SB/SH/SW; loads reject 011, 110 and 111.
  function automatic logic f3_unsupported(input logic we, input logic [2:0] f3);
    logic bad;
    if (we) begin
      bad = (f3 > F3_SW);
    end else begin
      bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    end
    return bad;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    case (f3[1:0])
      2'b01:   mis = off[0];
      2'b10:   mis = |off;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Combinational lane logic: load byte/halfword extract with sign or zero
// extension, and sub-word store merge into a previously read word.
module mau_lane_align
  import mau_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [3:0]  lane_en;
  logic [31:0] src_rep;

  // Halfword uses only offset bit 1, so a misaligned halfword lands on its aligned lane.
  always_comb begin
    byte_sel = rdata_i[{offset_i, 3'b000} +: 8];
    half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_LB:   load_data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   load_data_o = {{16{half_sel[15]}}, half_sel};
      F3_LW:   load_data_o = rdata_i;
      F3_LBU:  load_data_o = {24'd0, byte_sel};
      F3_LHU:  load_data_o = {16'd0, half_sel};
      default: load_data_o = 32'd0;
    endcase
  end

  always_comb begin
    lane_en = 4'b1111;
    src_rep = wdata_i;
    if (funct3_i == F3_SB) begin
      lane_en = 4'b0001 << offset_i;
      src_rep = {4{wdata_i[7:0]}};
    end else if (funct3_i == F3_SH) begin
      lane_en = offset_i[1] ? 4'b1100 : 4'b0011;
      src_rep = {2{wdata_i[15:0]}};
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign merged_o[8*gi +: 8] = lane_en[gi] ? src_rep[8*gi +: 8] : rdata_i[8*gi +: 8];
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store requester over a word-addressed data memory.
// Optional MAU_MISALIGN_TRAP_EN turns misaligned LH/LHU/SH/LW/SW into error responses.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_write_en,
  output logic [31:0] mem_write_addr,
  output logic [31:0] mem_write_data,
  output logic [31:0] mem_read_addr,
  input  logic [31:0] mem_read_data
);

  mau_state_e        state_q, state_d;
  logic [ADDR_W-1:0] word_q;
  logic [1:0]        off_q;
  logic [2:0]        funct3_q;
  logic [31:0]       wdata_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [31:0]       resp_rdata_q;

  logic              accept;
  logic              req_err;
  logic [31:0]       load_data;
  logic [31:0]       merged_word;
  logic [31-ADDR_W-2:0] unused_addr_hi;

  // Address bits above the memory's word index wrap silently.
  assign unused_addr_hi = req_addr[31:ADDR_W+2];

  assign accept = req_valid && (state_q == ST_IDLE);

`ifdef MAU_MISALIGN_TRAP_EN
  assign req_err = f3_unsupported(req_we, req_funct3) || is_misaligned(req_funct3, req_addr[1:0]);
`else
  assign req_err = f3_unsupported(req_we, req_funct3);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && !req_err) begin
          if (!req_we)                  state_d = ST_LOAD;
          else if (req_funct3 == F3_SW) state_d = ST_STORE;
          else                          state_d = ST_RMW;
        end
      end
      ST_LOAD:  state_d = ST_IDLE;
      ST_RMW:   state_d = ST_STORE;
      ST_STORE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready    = (state_q == ST_IDLE);
    mem_write_en = (state_q == ST_STORE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q       <= '0;
      off_q        <= '0;
      funct3_q     <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            word_q   <= req_addr[ADDR_W+1:2];
            off_q    <= req_addr[1:0];
            funct3_q <= req_funct3;
            wdata_q  <= req_wdata;
            if (req_err) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          resp_valid_q <= 1'b1;
          resp_rdata_q <= load_data;
        end
        ST_RMW:   wdata_q <= merged_word;
        ST_STORE: resp_valid_q <= 1'b1;
        default: ;
      endcase
    end
  end

  mau_lane_align u_lane_align (
    .funct3_i    (funct3_q),
    .offset_i    (off_q),
    .rdata_i     (mem_read_data),
    .wdata_i     (wdata_q),
    .load_data_o (load_data),
    .merged_o    (merged_word)
  );

  assign mem_read_addr  = {{(32-ADDR_W){1'b0}}, word_q};
  assign mem_write_addr = {{(32-ADDR_W){1'b0}}, word_q};
  assign mem_write_data = wdata_q;
  assign resp_valid     = resp_valid_q;
  assign resp_err       = resp_err_q;
  assign resp_rdata     = resp_rdata_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store requester for the word-addressed data memory; sits in the MEM stage between the pipeline and the data memory. Converts byte-addressed RV32I loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) into word-granular memory accesses. Performs lane extraction and sign/zero extension on loads, and read-modify-write for sub-word stores. Exposes a valid/ready request port with a stall-producing ready and a single-cycle response pulse.

## Interface
- ADDR_W, 12, word-index width driven to memory (4096 words)
- clk  in  1  clock, all logic on posedge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle, request accepted when valid&ready
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 of the load/store
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low bytes used for SB/SH)
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data, 0 for stores/errors
- resp_err  out  1  misaligned or unsupported funct3
- mem_write_en  out  1  memory write strobe
- mem_write_addr  out  32  word index, zero-extended from ADDR_W
- mem_write_data  out  32  full word to write
- mem_read_addr  out  32  word index, zero-extended from ADDR_W
- mem_read_data  in  32  combinational read data for mem_read_addr

## Operation
- Word index = req_addr[ADDR_W+1:2]; higher address bits ignored (wrap).
- States: IDLE, LOAD, RMW, STORE. req_ready = (state == IDLE).
- IDLE, accept: capture addr, wdata, funct3, we. Load → LOAD; SW → STORE (wdata_q = req_wdata); SB/SH → RMW; error → stay IDLE, next cycle resp_valid=1, resp_err=1, resp_rdata=0, no memory access.
- Unsupported funct3: loads 011/110/111, stores 011–111 → error regardless of macro.
- LOAD: mem_read_addr = word index; select byte (addr[1:0]) or halfword (addr[1]); sign-extend LB/LH, zero-extend LBU/LHU, LW passthrough; register into resp_rdata; → IDLE with resp_valid=1.
- RMW: read word; replace byte lane addr[1:0] with wdata[7:0] (SB) or halfword lane addr[1] with wdata[15:0] (SH); register merged word in wdata_q; → STORE.
- STORE: mem_write_en=1, mem_write_addr = word index, mem_write_data = wdata_q; → IDLE with resp_valid=1, resp_rdata=0.
- mem_write_en is high only in STORE; mem_read_addr/mem_write_addr driven from captured address in all states.
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, mem_write_en 0, addresses 0, mem_write_data 0.
- Reset mid-operation: return to IDLE next cycle; pending RMW dropped with no partial write; no resp_valid.

## Timing
- Accept in cycle N. Error: resp_valid at N+1. Load and SW: resp_valid at N+2. SB/SH: write in N+2, resp_valid at N+3.
- resp_valid lasts exactly one cycle, no backpressure; it coincides with IDLE, so a new request may be accepted in the same cycle (back-to-back).
- Memory write commits on the posedge ending the STORE cycle; a load issued in the following IDLE sees the new data.

## Configuration
- MAU_MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]≠0 → error response.
- Undefined: misaligned accesses proceed with low address bits forced to alignment (halfword clears bit 0, word clears bits 1:0); resp_err only for unsupported funct3.

## Structure
- Package mau_pkg: state enum, funct3 constants (LB 000, LH 001, LW 010, LBU 100, LHU 101, SB 000, SH 001, SW 010).
- Sub-module mau_lane_align: combinational load extract/extend and store lane merge, shared by LOAD and RMW.

## Test plan
- mem[3]=0x8899AABB; LB addr 0x0E → resp_rdata 0xFFFFFF99 at N+2; LBU same → 0x00000099.
- SW addr 0x10 data 0xDEADBEEF → mem_write_en high at N+1, mem_write_addr 4, resp_valid N+2; LW 0x10 → 0xDEADBEEF.
- mem[4]=0x11223344; SB 0x11 data 0xAB → write 0x1122AB44 at N+2; SH 0x12 data 0xCAFE → 0xCAFEAB44.
- With MAU_MISALIGN_TRAP_EN, LW 0x13 → resp_err=1, resp_rdata 0 at N+1, no write; without, returns word at 0x10.
- Assert rst_n low during RMW of an SB → mem_write_en never asserts, memory unchanged, req_ready 1 after reset.
- Back-to-back SW then LW same address, second request accepted in resp_valid cycle → loaded data equals stored data.
